// File: rtl/hub75_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg
// Shared definitions for the HUB75 row-scan controller:
//   - default geometry/timing constants (columns, row-address width,
//     tick divider, minimum display dwell)
//   - bit positions of the six colour bits inside the framebuffer word
//   - the scan/row-switch state enumeration
// ---------------------------------------------------------------------------
package hub75_pkg;

    localparam int DEF_COLS     = 64;
    localparam int DEF_ROW_BITS = 5;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_DWELL    = 256;

    // Framebuffer word layout {R1,G1,B1,R2,G2,B2}
    localparam int RD_R1 = 5;
    localparam int RD_G1 = 4;
    localparam int RD_B1 = 3;
    localparam int RD_R2 = 2;
    localparam int RD_G2 = 1;
    localparam int RD_B2 = 0;

    // Shift states followed by the three row-switch states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SETUP,
        ST_CLKHI,
        ST_CLKLO,
        ST_DONE,
        ST_SW_BLANK,
        ST_SW_ADDR,
        ST_SW_LAT
    } scan_state_t;

endpackage

// File: rtl/prescaler.sv
// ---------------------------------------------------------------------------
// prescaler
// Issues a one-clk tick every NUM clks. The counter and the tick are both
// cleared by the synchronous reset, so the first tick after reset appears
// NUM clks after rst is released.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   tick  out  one-clk pulse every NUM clks
// ---------------------------------------------------------------------------
module prescaler #(
    parameter int NUM = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (NUM > 1) ? $clog2(NUM) : 1;

    logic [W-1:0] cnt;

    // Count 0..NUM-1 and fire the tick on the wrap clk
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == W'(NUM - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hub75_scan_ctrl
// Row-scan engine for a 1-bit-per-channel HUB75 panel. Each row is fetched
// pixel pair by pixel pair from a framebuffer read port and shifted into the
// panel while the previous row is still on display. Once the new row is fully
// shifted and the old one has been shown for at least DWELL ticks, the panel
// is blanked, re-addressed, latched and unblanked.
//
// Optional build macro HUB75_TEST_PATTERN_EN: when defined the framebuffer is
// not read (rd_en stays 0) and a diagonal colour pattern derived from
// (column + row) is shifted instead, with identical FETCH/WAIT timing.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   enable               run scanning; low stops at the next row boundary
//   rd_row, rd_col       framebuffer read address (row being shifted)
//   rd_en                read strobe; rd_data is valid one clk later
//   rd_data              {R1,G1,B1,R2,G2,B2}
//   h75_r1..h75_b2       panel colour data (upper/lower half)
//   h75_addr             panel row select
//   h75_clk              shift clock, panel samples on its rising edge
//   h75_lat              row latch
//   h75_oe               output enable, active low
//   frame_start          one-clk pulse after row 0 has been latched
// ---------------------------------------------------------------------------
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int DWELL    = DEF_DWELL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic [ROW_BITS-1:0]     rd_row,
    output logic [$clog2(COLS)-1:0] rd_col,
    output logic                    rd_en,
    input  logic [5:0]              rd_data,
    output logic                    h75_r1,
    output logic                    h75_g1,
    output logic                    h75_b1,
    output logic                    h75_r2,
    output logic                    h75_g2,
    output logic                    h75_b2,
    output logic [ROW_BITS-1:0]     h75_addr,
    output logic                    h75_clk,
    output logic                    h75_lat,
    output logic                    h75_oe,
    output logic                    frame_start
);

    localparam int COL_BITS = $clog2(COLS);
    localparam int DW_BITS  = $clog2(DWELL + 1);

    scan_state_t          state;
    scan_state_t          state_next;
    logic                 tick;
    logic [ROW_BITS-1:0]  shift_row;
    logic [COL_BITS-1:0]  column;
    logic [DW_BITS-1:0]   dwell_cnt;
    logic                 dwell_ok;
    logic                 sw_exit;
    logic [5:0]           pix;
    logic [5:0]           fetched;

    // Pixel source: either the framebuffer word or a (column + row) pattern
`ifdef HUB75_TEST_PATTERN_EN
    localparam bit FETCH_READS = 1'b0;
    logic [2:0] pat;
    logic       unused_rd_data;
    assign pat            = 3'(int'(column) + int'(shift_row));
    assign fetched        = {pat, ~pat};
    assign unused_rd_data = ^rd_data;
`else
    localparam bit FETCH_READS = 1'b1;
    assign fetched = rd_data;
`endif

    prescaler #(
        .NUM (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign dwell_ok = (dwell_cnt >= DW_BITS'(DWELL));
    assign sw_exit  = (state == ST_SW_LAT) && tick;

    assign rd_row = shift_row;
    assign rd_col = column;

    assign h75_r1 = pix[RD_R1];
    assign h75_g1 = pix[RD_G1];
    assign h75_b1 = pix[RD_B1];
    assign h75_r2 = pix[RD_R2];
    assign h75_g2 = pix[RD_G2];
    assign h75_b2 = pix[RD_B2];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. FETCH and WAIT last one clk each; all panel-side
    // states advance on ticks. DONE waits for the displayed row's dwell.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (enable) state_next = ST_FETCH;
            ST_FETCH:    state_next = ST_WAIT;
            ST_WAIT:     state_next = ST_SETUP;
            ST_SETUP:    if (tick) state_next = ST_CLKHI;
            ST_CLKHI:    if (tick) state_next = ST_CLKLO;
            ST_CLKLO: begin
                if (tick) begin
                    state_next = (column == COL_BITS'(COLS - 1)) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE:     if (dwell_ok) state_next = ST_SW_BLANK;
            ST_SW_BLANK: if (tick) state_next = ST_SW_ADDR;
            ST_SW_ADDR:  if (tick) state_next = ST_SW_LAT;
            ST_SW_LAT: begin
                if (tick) begin
                    state_next = enable ? ST_FETCH : ST_IDLE;
                end
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    // Pure state-decoded outputs
    always_comb begin
        rd_en   = 1'b0;
        h75_clk = 1'b0;
        h75_lat = 1'b0;
        case (state)
            ST_FETCH:  rd_en   = FETCH_READS;
            ST_CLKHI:  h75_clk = 1'b1;
            ST_SW_LAT: h75_lat = 1'b1;
            default: ;
        endcase
    end

    // Datapath: colour capture, column/row counters, blanking, addressing.
    // OE is only raised for the switch and dropped on the same clk the latch
    // ends, so an idle controller keeps showing the last latched row.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_row   <= '0;
            column      <= '0;
            pix         <= '0;
            h75_oe      <= 1'b1;
            h75_addr    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) column <= '0;
                end
                ST_WAIT: begin
                    pix <= fetched;
                end
                ST_CLKLO: begin
                    if (tick) column <= column + COL_BITS'(1);
                end
                ST_DONE: begin
                    if (dwell_ok) h75_oe <= 1'b1;
                end
                ST_SW_BLANK: begin
                    if (tick) h75_addr <= shift_row;
                end
                ST_SW_LAT: begin
                    if (tick) begin
                        h75_oe      <= 1'b0;
                        frame_start <= (shift_row == '0);
                        shift_row   <= shift_row + ROW_BITS'(1);
                        column      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Dwell counter: ticks of OE-low time, saturating at DWELL. Starts out
    // satisfied so the very first row can be latched without waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= DW_BITS'(DWELL);
        end else if (sw_exit) begin
            dwell_cnt <= '0;
        end else if (tick && !h75_oe && !dwell_ok) begin
            dwell_cnt <= dwell_cnt + DW_BITS'(1);
        end
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hub75_scan_ctrl
// Scoreboard bench for hub75_scan_ctrl (COLS=4, ROW_BITS=2, CLK_DIV=1,
// DWELL=8). The stimulus side fills a framebuffer and, for every row it
// expects the controller to scan, queues the reads, shifted pixels and latch
// address. A monitor watches the panel pins and read port and pops/compares
// as events appear.
// ---------------------------------------------------------------------------
module tb_hub75_scan_ctrl;

    localparam int COLS     = 4;
    localparam int ROW_BITS = 2;
    localparam int CLK_DIV  = 1;
    localparam int DWELL    = 8;
    localparam int ROWS     = 1 << ROW_BITS;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [ROW_BITS-1:0] rd_row;
    logic [1:0]          rd_col;
    logic                rd_en;
    logic [5:0]          rd_data;
    logic                h75_r1, h75_g1, h75_b1, h75_r2, h75_g2, h75_b2;
    logic [ROW_BITS-1:0] h75_addr;
    logic                h75_clk;
    logic                h75_lat;
    logic                h75_oe;
    logic                frame_start;

    int checks   = 0;
    int failures = 0;

    logic [5:0] fb [0:ROWS-1][0:COLS-1];
    logic [5:0] pix_q [$];
    int         rd_q  [$];
    int         lat_q [$];
    int         model_row = 0;

    hub75_scan_ctrl #(
        .COLS     (COLS),
        .ROW_BITS (ROW_BITS),
        .CLK_DIV  (CLK_DIV),
        .DWELL    (DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .h75_r1      (h75_r1),
        .h75_g1      (h75_g1),
        .h75_b1      (h75_b1),
        .h75_r2      (h75_r2),
        .h75_g2      (h75_g2),
        .h75_b2      (h75_b2),
        .h75_addr    (h75_addr),
        .h75_clk     (h75_clk),
        .h75_lat     (h75_lat),
        .h75_oe      (h75_oe),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference pixel for a given row/column
    function automatic logic [5:0] expPixel(input int r, input int c);
`ifdef HUB75_TEST_PATTERN_EN
        logic [2:0] p;
        p = 3'(r + c);
        return {p, ~p};
`else
        return fb[r][c];
`endif
    endfunction

    // Queue everything the next n scanned rows must produce
    task automatic pushRows(input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < COLS; c++) begin
                pix_q.push_back(expPixel(model_row, c));
`ifndef HUB75_TEST_PATTERN_EN
                rd_q.push_back(model_row * 16 + c);
`endif
            end
            lat_q.push_back(model_row);
            model_row = (model_row + 1) % ROWS;
        end
    endtask

    // Run n rows, dropping enable somewhere inside the last row, then idle
    task automatic applyStimulus(input int n, input bit release_rst);
        int k;
        int i;
        pushRows(n);
        enable = 1'b1;
        if (release_rst) begin
            @(negedge clk);
            rst = 1'b0;
        end
        k = $urandom_range(1, COLS - 1);
        for (i = 0; i < 3000 && pix_q.size() > k; i++) @(negedge clk);
        checkOutput("timeout_shift", (pix_q.size() <= k), 1);
        enable = 1'b0;
        for (i = 0; i < 3000 && (pix_q.size() != 0 || lat_q.size() != 0 || rd_q.size() != 0); i++)
            @(negedge clk);
        checkOutput("timeout_drain", (pix_q.size() == 0 && lat_q.size() == 0 && rd_q.size() == 0), 1);
        repeat (30) @(negedge clk);
        checkOutput("idle_oe_low", h75_oe, 0);
        checkOutput("idle_no_clk", h75_clk, 0);
    endtask

    // Framebuffer read port: data appears one clk after the strobe,
    // random garbage otherwise
    initial begin
        logic                req;
        logic [ROW_BITS-1:0] rr;
        logic [1:0]          rc;
        rd_data = '0;
        forever begin
            @(negedge clk);
            req = rd_en;
            rr  = rd_row;
            rc  = rd_col;
            @(posedge clk);
            #1;
            rd_data = req ? fb[rr][rc] : 6'($urandom);
        end
    end

    // Monitor / scoreboard
    logic                hclk_prev, lat_prev, oe_prev;
    logic [ROW_BITS-1:0] addr_prev;
    logic [5:0]          pins, pins_prev;
    int                  oe_low, lat_len, cur_lat_row;

    always @(negedge clk) begin
        if (rst) begin
            hclk_prev   = 1'b0;
            lat_prev    = 1'b0;
            oe_prev     = 1'b1;
            addr_prev   = '0;
            pins_prev   = '0;
            oe_low      = 0;
            lat_len     = 0;
            cur_lat_row = -1;
        end else begin
            pins = {h75_r1, h75_g1, h75_b1, h75_r2, h75_g2, h75_b2};
`ifdef HUB75_TEST_PATTERN_EN
            checkOutput("rd_en_low", rd_en, 0);
`else
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    checkOutput("unexpected_read", 1, 0);
                end else begin
                    int e;
                    e = rd_q.pop_front();
                    checkOutput("rd_row", rd_row, e / 16);
                    checkOutput("rd_col", rd_col, e % 16);
                end
            end
`endif
            if (h75_clk && !hclk_prev) begin
                checkOutput("pins_stable_setup", pins, pins_prev);
                if (pix_q.size() == 0) checkOutput("unexpected_shift", 1, 0);
                else checkOutput("pixel", pins, pix_q.pop_front());
            end
            if (h75_addr != addr_prev) checkOutput("addr_change_blanked", h75_oe, 1);
            if (h75_lat) begin
                if (!lat_prev) begin
                    if (lat_q.size() == 0) begin
                        checkOutput("unexpected_latch", 1, 0);
                        cur_lat_row = -1;
                    end else begin
                        cur_lat_row = lat_q.pop_front();
                        checkOutput("lat_addr", h75_addr, cur_lat_row);
                    end
                    checkOutput("lat_oe_blank", h75_oe, 1);
                    lat_len = 1;
                end else begin
                    lat_len++;
                end
            end else if (lat_prev) begin
                checkOutput("lat_len", lat_len, 1);
                checkOutput("oe_after_lat", h75_oe, 0);
                checkOutput("frame_start", frame_start, (cur_lat_row == 0));
            end else if (frame_start) begin
                checkOutput("frame_start_spurious", frame_start, 0);
            end
            if (!h75_oe) begin
                oe_low++;
            end else if (!oe_prev) begin
                checkOutput("dwell_min", (oe_low >= DWELL), 1);
                oe_low = 0;
            end
            hclk_prev = h75_clk;
            lat_prev  = h75_lat;
            oe_prev   = h75_oe;
            addr_prev = h75_addr;
            pins_prev = pins;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int i;
        rst    = 1'b1;
        enable = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fb[r][c] = (c % 2 == 0) ? 6'b101010 : 6'b010101;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_oe", h75_oe, 1);
        checkOutput("rst_clk", h75_clk, 0);
        checkOutput("rst_lat", h75_lat, 0);
        checkOutput("rst_addr", h75_addr, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_rd_en", rd_en, 0);
        checkOutput("rst_pins", {h75_r1, h75_g1, h75_b1, h75_r2, h75_g2, h75_b2}, 0);
        checkOutput("rst_rd_addr", {rd_row, rd_col}, 0);

        // Out of reset with enable already high: rows 0,1,2,3,0
        enable = 1'b1;
        applyStimulus(5, 1'b1);

        // Random framebuffers, random run lengths, resume from stored row
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    fb[r][c] = 6'($urandom);
            applyStimulus($urandom_range(2, 6), 1'b0);
        end

        // Reset while the shift clock is high
        pushRows(2);
        enable = 1'b1;
        for (i = 0; i < 500 && !h75_clk; i++) @(negedge clk);
        checkOutput("timeout_clkhi", h75_clk, 1);
        rst    = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_clk", h75_clk, 0);
        checkOutput("rst_mid_oe", h75_oe, 1);
        checkOutput("rst_mid_lat", h75_lat, 0);
        checkOutput("rst_mid_addr", h75_addr, 0);
        pix_q.delete();
        rd_q.delete();
        lat_q.delete();
        model_row = 0;
        repeat (2) @(negedge clk);
        applyStimulus(3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Row-scan engine for a 1-bit-per-channel HUB75 panel.
- Pulls pixel pairs (upper/lower half) from an upstream framebuffer read port.
- Shifts each row into the panel, then blanks, re-addresses, latches and unblanks.
- Shifting of row n+1 overlaps the display dwell of row n; it sits between the framebuffer and the H75_* pins.

Parameters:
- COLS, 64, columns per row; power of two, >=2.
- ROW_BITS, 5, row-address width; the panel has 2^ROW_BITS scan rows.
- CLK_DIV, 2, clk cycles per tick; >=1; all panel-side timing advances on ticks.
- DWELL, 256, minimum ticks each row stays displayed (OE low).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run scanning; low stops at the next row boundary
- rd_row  out  ROW_BITS  framebuffer read row
- rd_col  out  $clog2(COLS)  framebuffer read column
- rd_en  out  1  read strobe; rd_data valid exactly 1 clk later
- rd_data  in  6  {R1,G1,B1,R2,G2,B2}
- h75_r1, h75_g1, h75_b1, h75_r2, h75_g2, h75_b2  out  1 each  pixel data
- h75_addr  out  ROW_BITS  row select (A..E)
- h75_clk  out  1  shift clock; panel samples on rising edge
- h75_lat  out  1  latch
- h75_oe  out  1  output enable, active low (1 = blanked)
- frame_start  out  1  one-clk pulse when row 0 is latched

Behaviour:
- Reset values:
  - all outputs 0 except h75_oe=1.
  - Internal state: shift row = 0, column = 0, dwell satisfied, state IDLE.
- Tick: a divider counter issues a one-clk tick every CLK_DIV clks and is cleared by rst.
- Shift FSM (IDLE, FETCH, WAIT, SETUP, CLKHI, CLKLO, DONE):
  - IDLE: if enable, go to FETCH with column 0.
  - FETCH: assert rd_en for exactly 1 clk with rd_row = shift row and rd_col = column, then go to WAIT.
  - WAIT: 1 clk; register rd_data onto the h75 colour pins, then go to SETUP.
  - SETUP, CLKHI, CLKLO: one tick each.
    - h75_clk=1 in CLKHI only.
    - Data is stable through the whole of SETUP and CLKHI.
  - After CLKLO: if column == COLS-1, go to DONE; else increment column and go to FETCH.
- Dwell counter:
  - Counts ticks while h75_oe=0.
  - Saturates at DWELL.
  - "Dwell satisfied" means count >= DWELL; it is forced satisfied after reset.
- Row switch (SW_BLANK, SW_ADDR, SW_LAT, one tick each):
  - Entered from DONE when dwell is satisfied.
  - SW_BLANK: h75_oe=1.
  - SW_ADDR: h75_addr <= shift row.
  - SW_LAT: h75_lat=1.
  - On exiting SW_LAT, in the same clk: h75_lat=0, h75_oe=0, dwell counter cleared.
- After the switch:
  - frame_start pulses if the latched row was 0.
  - Shift row increments, wrapping 2^ROW_BITS-1 -> 0.
  - Go to FETCH if enable is high, else IDLE.
- Enable:
  - enable is sampled only in IDLE and at the end of a row switch; a mid-row deassert completes the current row and switch.
  - IDLE keeps the last row displayed (oe=0). Exception: right after reset, oe stays 1.
  - Re-enable restarts from the stored shift row.
- rst mid-operation: everything returns to reset values on the next clk, regardless of tick phase.
- Column and row counters wrap modulo their width; no other arithmetic.

Optional Feature:
- Macro HUB75_TEST_PATTERN_EN.
- Defined:
  - rd_en is held 0.
  - Pixel data = {p, ~p}, where p = (column + shift row)[2:0] mapped R,G,B = p[2],p[1],p[0].
  - FETCH/WAIT timing is unchanged.
- Undefined: data comes from rd_data as above.

Decomposition:
- Package hub75_pkg holds:
  - the state enum;
  - rd_data bit indices (R1=5 … B2=0);
  - the default COLS, ROW_BITS and DWELL constants.
- Tick generation reuses the existing prescaler module (NUM=CLK_DIV); there is no other sub-module.

Test Plan:
All scenarios use COLS=4, ROW_BITS=2, CLK_DIV=1, DWELL=8.
- Reset with enable=1; rd_data = column-indexed 6'b101010/010101 alternating.
  -> 4 h75_clk rising edges with pins matching the prior-clk rd_data; then oe=1, addr=0, one-tick lat pulse, oe=0 with lat=0, frame_start pulse.
- Continuous run.
  -> addr sequence 0,1,2,3,0.
  -> Each oe-low interval is >= 8 ticks.
  -> frame_start occurs every 4th switch.
- rd_en timing.
  -> Exactly one rd_en per column, rd_col 0..3, rd_row = next row.
  -> Colour pins change only in WAIT, never while h75_clk=1.
- Deassert enable at column 2.
  -> Row completes and switches; block enters IDLE with oe=0.
  -> Reassert: resumes with the next row; no duplicate latch.
- rst pulsed during CLKHI.
  -> Next clk: h75_clk=0, oe=1, lat=0, addr=0; first latched row afterwards is 0.
- HUB75_TEST_PATTERN_EN defined.
  -> rd_en is never 1.
  -> Row 1, column 2 shifts R1G1B1=011 and R2G2B2=100.
